// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame admission and retirement control for the R22SDF FFT and its bit-reversal stage
// Optional macro FRAME_CNT_EN enables the completed-output-frame counter on o_frame_cnt.
module fft_frame_sequencer #(
  parameter int DWIDTH     = 32,
  parameter int MAX_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       cfg_point,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              o_cfg_err,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [10:0]       o_point,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              br_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_ovf_err,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_STREAM} state_e;

  state_e            state_q, state_d;
  logic [10:0]       point_q, point_d;
  logic [10:0]       in_cnt_q, in_cnt_d;
  logic [10:0]       out_cnt_q, out_cnt_d;
  logic [1:0]        inflight_q, inflight_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              cfg_err_q, cfg_err_d;
  logic              ovf_q, ovf_d;

  logic        cfg_xfer, cfg_legal, frame_open, s_accept;
  logic        in_last, br_ok, out_last;
  logic [10:0] point_m1;

  // Legal sizes are single-bit values above 1; 11 bits cap the range at 1024.
  assign cfg_legal  = (cfg_point != 11'd0) && !cfg_point[0] &&
                      ((cfg_point & (cfg_point - 11'd1)) == 11'd0);
  assign cfg_xfer   = cfg_valid & cfg_ready;
  assign frame_open = (state_q == S_STREAM);
  assign s_accept   = s_valid & s_ready;
  assign point_m1   = point_q - 11'd1;
  assign in_last    = s_accept && (in_cnt_q == point_m1);
  assign br_ok      = br_valid && (inflight_q != 2'd0);
  assign out_last   = br_ok && (out_cnt_q == point_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_xfer && cfg_legal) state_d = S_READY;
      S_READY:  if (s_accept) state_d = S_STREAM;
      S_STREAM: if (in_last) state_d = S_READY;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == S_IDLE) || ((state_q == S_READY) && (inflight_q == 2'd0));
    s_ready   = ((state_q == S_READY) || (state_q == S_STREAM)) && !(cfg_valid && cfg_ready) &&
                (({1'b0, inflight_q} + {2'b00, frame_open}) < 3'(MAX_FRAMES));
    o_sof     = br_ok && (out_cnt_q == 11'd0);
    o_eof     = out_last;
    o_busy    = frame_open || (inflight_q != 2'd0);
  end

  always_comb begin
    point_d    = (cfg_xfer && cfg_legal) ? cfg_point : point_q;
    cfg_err_d  = cfg_xfer && !cfg_legal;
    data_d     = s_accept ? s_data : data_q;
    valid_d    = s_accept;
    in_cnt_d   = in_last ? 11'd0 : (s_accept ? in_cnt_q + 11'd1 : in_cnt_q);
    out_cnt_d  = out_last ? 11'd0 : (br_ok ? out_cnt_q + 11'd1 : out_cnt_q);
    ovf_d      = ovf_q || (br_valid && (inflight_q == 2'd0));
    inflight_d = inflight_q;
    // A frame entering and one retiring in the same cycle cancel out.
    if (in_last && !out_last) begin
      inflight_d = inflight_q + 2'd1;
    end else if (out_last && !in_last) begin
      inflight_d = inflight_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      point_q    <= 11'd0;
      in_cnt_q   <= 11'd0;
      out_cnt_q  <= 11'd0;
      inflight_q <= 2'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      point_q    <= point_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cfg_err_q  <= cfg_err_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = out_last ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`else
  assign o_frame_cnt = 16'h0000;
`endif

  assign o_point   = point_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_cfg_err = cfg_err_q;
  assign o_ovf_err = ovf_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed self-checking bench for fft_frame_sequencer
// Three-frame pipeline depth so input completion and eof can coincide.
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cfg_point;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        o_cfg_err;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [10:0] o_point;
  logic [31:0] o_data;
  logic        o_valid;
  logic        br_valid;
  logic        o_sof;
  logic        o_eof;
  logic        o_busy;
  logic        o_ovf_err;
  logic [15:0] o_frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] wide_point;

`ifdef FRAME_CNT_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  fft_frame_sequencer #(.DWIDTH(32), .MAX_FRAMES(3)) dut (
    .clk(clk), .reset(reset),
    .cfg_point(cfg_point), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .o_cfg_err(o_cfg_err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .o_point(o_point), .o_data(o_data), .o_valid(o_valid),
    .br_valid(br_valid), .o_sof(o_sof), .o_eof(o_eof), .o_busy(o_busy),
    .o_ovf_err(o_ovf_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cfg_try(input logic [10:0] pt, input logic exp_err, input logic [10:0] exp_pt);
    cfg_point = pt;
    cfg_valid = 1'b1;
    settle();
    chk("cfg_ready_on_offer", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", 32'(o_cfg_err), 32'(exp_err));
    chk("cfg_point_out", 32'(o_point), 32'(exp_pt));
    step();
    chk("cfg_err_clear", 32'(o_cfg_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cfg_point = 11'd0; cfg_valid = 1'b0;
    s_data = 32'd0; s_valid = 1'b0; br_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    settle();
    chk("rst_point", 32'(o_point), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ovf", 32'(o_ovf_err), 32'd0);
    chk("rst_cfg_err", 32'(o_cfg_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);

    cfg_try(11'd16, 1'b0, 11'd16);
    chk("ready_after_cfg", 32'(s_ready), 32'd1);
    cfg_try(11'd24, 1'b1, 11'd16);
    cfg_try(11'd0, 1'b1, 11'd16);
    wide_point = 12'd2048;
    cfg_try(wide_point[10:0], 1'b1, 11'd16);

    // Frames A and B back to back, 32 continuous samples.
    for (int i = 0; i < 32; i++) begin
      s_data = 32'(i);
      s_valid = 1'b1;
      settle();
      chk("s_ready_ab", 32'(s_ready), 32'd1);
      step();
      chk("o_valid_ab", 32'(o_valid), 32'd1);
      chk("o_data_ab", o_data, 32'(i));
    end
    s_data = 32'd200;
    step();
    chk("o_data_c0", o_data, 32'd200);
    chk("s_ready_full", 32'(s_ready), 32'd0);
    s_data = 32'd201;
    step();
    chk("o_valid_stall", 32'(o_valid), 32'd0);
    chk("o_data_hold", o_data, 32'd200);
    s_valid = 1'b0;

    // Retire frame A.
    for (int k = 0; k < 16; k++) begin
      br_valid = 1'b1;
      settle();
      chk("sof_a", 32'(o_sof), 32'(k == 0));
      chk("eof_a", 32'(o_eof), 32'(k == 15));
      if (k == 15) chk("s_ready_before_eof", 32'(s_ready), 32'd0);
      step();
    end
    br_valid = 1'b0;
    settle();
    chk("s_ready_after_eof", 32'(s_ready), 32'd1);
    chk("cfg_ready_inflight", 32'(cfg_ready), 32'd0);

    // Frame B output up to its 15th sample, then frame C input to its 15th.
    for (int k = 0; k < 15; k++) begin
      br_valid = 1'b1;
      settle();
      chk("sof_b", 32'(o_sof), 32'(k == 0));
      chk("eof_b", 32'(o_eof), 32'd0);
      step();
    end
    br_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      s_data = 32'(201 + i);
      s_valid = 1'b1;
      step();
      chk("o_data_c", o_data, 32'(201 + i));
    end
    s_data = 32'd215;
    br_valid = 1'b1;
    settle();
    chk("eof_b_coincide", 32'(o_eof), 32'd1);
    chk("s_ready_coincide", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    br_valid = 1'b0;
    settle();
    chk("o_data_c_last", o_data, 32'd215);
    chk("busy_one_left", 32'(o_busy), 32'd1);
    chk("cfg_ready_one_left", 32'(cfg_ready), 32'd0);

    // Retire frame C; nothing remains in flight afterwards.
    for (int k = 0; k < 16; k++) begin
      br_valid = 1'b1;
      settle();
      chk("sof_c", 32'(o_sof), 32'(k == 0));
      chk("eof_c", 32'(o_eof), 32'(k == 15));
      step();
    end
    br_valid = 1'b0;
    settle();
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    chk("busy_idle", 32'(o_busy), 32'd0);
    chk("frame_cnt_3", 32'(o_frame_cnt), FC ? 32'd3 : 32'd0);

    // Stray br_valid: sticky overflow, no frame markers.
    br_valid = 1'b1;
    settle();
    chk("ovf_sof", 32'(o_sof), 32'd0);
    chk("ovf_eof", 32'(o_eof), 32'd0);
    step();
    br_valid = 1'b0;
    chk("ovf_set", 32'(o_ovf_err), 32'd1);
    step(); step();
    chk("ovf_sticky", 32'(o_ovf_err), 32'd1);

    // Minimum point size.
    cfg_point = 11'd2;
    cfg_valid = 1'b1;
    settle();
    chk("s_ready_cfg_block", 32'(s_ready), 32'd0);
    step();
    cfg_valid = 1'b0;
    chk("point_2", 32'(o_point), 32'd2);
    s_data = 32'd300;
    s_valid = 1'b1;
    step();
    settle();
    chk("p2_busy_open", 32'(o_busy), 32'd1);
    chk("p2_ready_open", 32'(s_ready), 32'd1);
    s_data = 32'd301;
    step();
    s_valid = 1'b0;
    settle();
    chk("p2_data", o_data, 32'd301);
    chk("p2_cfg_blocked", 32'(cfg_ready), 32'd0);
    br_valid = 1'b1;
    settle();
    chk("p2_sof", 32'(o_sof), 32'd1);
    chk("p2_eof0", 32'(o_eof), 32'd0);
    step();
    chk("p2_sof1", 32'(o_sof), 32'd0);
    chk("p2_eof1", 32'(o_eof), 32'd1);
    step();
    br_valid = 1'b0;
    settle();
    chk("frame_cnt_4", 32'(o_frame_cnt), FC ? 32'd4 : 32'd0);
    chk("p2_idle_busy", 32'(o_busy), 32'd0);

    // Reset with half a frame captured.
    cfg_try(11'd16, 1'b0, 11'd16);
    for (int i = 0; i < 8; i++) begin
      s_data = 32'(400 + i);
      s_valid = 1'b1;
      step();
    end
    chk("mid_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    s_valid = 1'b0;
    settle();
    chk("mr_point", 32'(o_point), 32'd0);
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_data", o_data, 32'd0);
    chk("mr_busy", 32'(o_busy), 32'd0);
    chk("mr_ovf", 32'(o_ovf_err), 32'd0);
    chk("mr_s_ready", 32'(s_ready), 32'd0);
    chk("mr_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("mr_frame_cnt", 32'(o_frame_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
